// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the uart_rx receiver: FSM states, parity
// encodings and the set of supported oversampling ratios.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  function automatic logic prescale_is_legal(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Edge/bit counters and mid-bit sampling for uart_rx.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around the bit centre.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic                  en,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_done,
  output logic                  bit_val
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_W-1:0] half, last;
  logic                  s_mid_q, s_mid_d;

  assign half     = prescale >> 1;
  assign last     = prescale - PRESCALE_W'(1);
  assign bit_done = en && (edge_cnt_q == last);
  assign bit_cnt  = bit_cnt_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    if (!en || bit_done) edge_cnt_d = '0;

    bit_cnt_d = bit_cnt_q;
    if (restart)       bit_cnt_d = '0;
    else if (bit_done) bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);

    s_mid_d = s_mid_q;
    if (en && (edge_cnt_q == half)) s_mid_d = rx_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      s_mid_q    <= 1'b1;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      s_mid_q    <= s_mid_d;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s_lo_q, s_lo_d, s_hi_q, s_hi_d;

  always_comb begin
    s_lo_d = s_lo_q;
    s_hi_d = s_hi_q;
    if (en && (edge_cnt_q == half - PRESCALE_W'(1))) s_lo_d = rx_in;
    if (en && (edge_cnt_q == half + PRESCALE_W'(1))) s_hi_d = rx_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_lo_q <= 1'b1;
      s_hi_q <= 1'b1;
    end else begin
      s_lo_q <= s_lo_d;
      s_hi_q <= s_hi_d;
    end
  end

  assign bit_val = (s_lo_q & s_mid_q) | (s_lo_q & s_hi_q) | (s_mid_q & s_hi_q);
`else
  assign bit_val = s_mid_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// Oversampled UART receiver: FSM, shift register, parity/stop checks, outputs.
// Optional UART_RX_MAJORITY_EN selects 2-of-3 voting in uart_rx_sampler.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Frame_Error
);

  // state  | meaning
  // IDLE   | line idle, waiting for RX_IN low
  // START  | start bit; a high sample means a glitch
  // DATA   | shifting DATA_WIDTH bits, LSB first
  // PARITY | parity bit check (only when PAR_EN latched)
  // STOP   | stop bit check, result publish, back-to-back detect

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 3);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  dv_q, dv_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;

  logic                  start_entry;
  logic                  bit_done, bit_val, par_exp;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [PRESCALE_W-1:0] prescale_legal;

  assign prescale_legal = prescale_is_legal(32'(Prescale)) ? Prescale
                                                           : PRESCALE_W'(PRESCALE_8);
  assign par_exp = (par_typ_q == PAR_ODD) ? ~^shift_q : ^shift_q;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_sampler (
    .clk      (CLK),
    .rst_n    (rst_n),
    .rx_in    (RX_IN),
    .en       (state_q != S_IDLE),
    .restart  (start_entry),
    .prescale (prescale_q),
    .bit_cnt  (bit_cnt),
    .bit_done (bit_done),
    .bit_val  (bit_val)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    p_data_d    = p_data_q;
    dv_d        = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    prescale_d  = prescale_q;
    start_entry = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!RX_IN) start_entry = 1'b1;
      end
      S_START: begin
        if (bit_done) state_d = bit_val ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_done) begin
          shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt == BIT_CNT_W'(DATA_WIDTH))
            state_d = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          if (bit_val != par_exp) perr_d = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (!bit_val) begin
            ferr_d = 1'b1;
          end else if (!perr_q) begin
            dv_d     = 1'b1;
            p_data_d = shift_q;
          end
          if (!RX_IN) start_entry = 1'b1;
          else        state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every frame start (idle or back-to-back) snapshots config and clears flags.
    if (start_entry) begin
      state_d    = S_START;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
      par_en_d   = PAR_EN;
      par_typ_d  = PAR_TYP;
      prescale_d = prescale_legal;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= PRESCALE_W'(PRESCALE_8);
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      prescale_q <= prescale_d;
    end
  end

  assign P_DATA       = p_data_q;
  assign Data_Valid   = dv_q;
  assign Parity_Error = perr_q;
  assign Frame_Error  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, parity, stop errors, glitches,
// back-to-back frames, illegal prescale and mid-frame reset.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Parity_Error;
  logic       Frame_Error;

  int         total  = 0;
  int         passed = 0;
  int         cyc    = 0;
  int         dv_cnt = 0;
  int         dv_wide = 0;
  logic       dv_prev = 1'b0;
  logic [7:0] dv_data_q[$];
  int         dv_cyc_q[$];
  int         start_cyc;
  int         start1;
  int         base;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .Prescale     (Prescale),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .Parity_Error (Parity_Error),
    .Frame_Error  (Frame_Error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse log: value and posedge index of every Data_Valid, plus width check.
  always @(negedge CLK) begin
    if (Data_Valid === 1'b1) begin
      dv_cnt <= dv_cnt + 1;
      dv_data_q.push_back(P_DATA);
      dv_cyc_q.push_back(cyc);
      if (dv_prev) dv_wide <= dv_wide + 1;
    end
    dv_prev <= (Data_Valid === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic par_on,
                            input logic par_bit, input logic stop_bit,
                            input logic [5:0] mid_ps);
    logic [5:0] saved;
    saved     = Prescale;
    start_cyc = cyc + 1;
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i], p);
      if (mid_ps != 6'd0 && i == 2) Prescale = mid_ps;
      if (mid_ps != 6'd0 && i == 5) Prescale = saved;
    end
    if (par_on) send_bit(par_bit, p);
    send_bit(stop_bit, p);
  endtask

  initial begin
    rst_n    = 1'b0;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = 6'd8;
    repeat (3) @(negedge CLK);
    chk("rst_p_data", 32'(P_DATA), 32'h00);
    chk("rst_dv",     32'(Data_Valid), 32'h0);
    chk("rst_perr",   32'(Parity_Error), 32'h0);
    chk("rst_ferr",   32'(Frame_Error), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge CLK);

    // 0xAA, odd parity (bit 1), prescale 8: 11 bits * 8 = 88 cycles
    PAR_EN = 1'b1; PAR_TYP = 1'b1; base = dv_cnt;
    send_frame(8'hAA, 8, 1'b1, 1'b1, 1'b1, 6'd0);
    send_bit(1'b1, 4);
    chk("aa_dv_count", 32'(dv_cnt - base), 32'd1);
    chk("aa_dv_data",  32'(dv_data_q[$]), 32'hAA);
    chk("aa_latency",  32'(dv_cyc_q[$] - start_cyc), 32'd88);
    chk("aa_p_data",   32'(P_DATA), 32'hAA);
    chk("aa_perr",     32'(Parity_Error), 32'h0);
    chk("aa_ferr",     32'(Frame_Error), 32'h0);

    // 0xBB even parity expects 0; sending 1 is a parity error
    PAR_TYP = 1'b0; base = dv_cnt;
    send_frame(8'hBB, 8, 1'b1, 1'b1, 1'b1, 6'd0);
    send_bit(1'b1, 4);
    chk("bb_perr",     32'(Parity_Error), 32'h1);
    chk("bb_dv_count", 32'(dv_cnt - base), 32'd0);
    chk("bb_p_data",   32'(P_DATA), 32'hAA);
    chk("bb_ferr",     32'(Frame_Error), 32'h0);

    // 0x3C has four ones: even parity bit 0; clears the parity flag
    base = dv_cnt;
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 6'd0);
    send_bit(1'b1, 4);
    chk("3c_perr",     32'(Parity_Error), 32'h0);
    chk("3c_dv_count", 32'(dv_cnt - base), 32'd1);
    chk("3c_p_data",   32'(P_DATA), 32'h3C);

    // Two-cycle low glitch is rejected silently
    base = dv_cnt;
    send_bit(1'b0, 2);
    send_bit(1'b1, 20);
    chk("gl_dv_count", 32'(dv_cnt - base), 32'd0);
    chk("gl_p_data",   32'(P_DATA), 32'h3C);
    chk("gl_perr",     32'(Parity_Error), 32'h0);
    chk("gl_ferr",     32'(Frame_Error), 32'h0);

    // 0xCC with stop bit 0, no parity
    PAR_EN = 1'b0; base = dv_cnt;
    send_frame(8'hCC, 8, 1'b0, 1'b0, 1'b0, 6'd0);
    send_bit(1'b1, 4);
    chk("cc_ferr",     32'(Frame_Error), 32'h1);
    chk("cc_dv_count", 32'(dv_cnt - base), 32'd0);
    chk("cc_p_data",   32'(P_DATA), 32'h3C);

    // Back-to-back at prescale 16 with a transient prescale change in frame 1
    Prescale = 6'd16; base = dv_cnt;
    send_frame(8'h5C, 16, 1'b0, 1'b0, 1'b1, 6'd8);
    start1 = start_cyc;
    send_frame(8'hDD, 16, 1'b0, 1'b0, 1'b1, 6'd0);
    send_bit(1'b1, 4);
    chk("b2b_dv_count", 32'(dv_cnt - base), 32'd2);
    chk("b2b_data0",    32'(dv_data_q[$-1]), 32'h5C);
    chk("b2b_data1",    32'(dv_data_q[$]), 32'hDD);
    chk("b2b_latency",  32'(dv_cyc_q[$-1] - start1), 32'd160);
    chk("b2b_spacing",  32'(dv_cyc_q[$] - dv_cyc_q[$-1]), 32'd160);
    chk("b2b_ferr",     32'(Frame_Error), 32'h0);

    // Illegal prescale 5 behaves as 8
    Prescale = 6'd5; base = dv_cnt;
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 6'd0);
    send_bit(1'b1, 4);
    chk("ill_dv_count", 32'(dv_cnt - base), 32'd1);
    chk("ill_dv_data",  32'(dv_data_q[$]), 32'h96);
    chk("ill_latency",  32'(dv_cyc_q[$] - start_cyc), 32'd80);

    // Reset during the data bits of 0xAA, then receive 0x11
    Prescale = 6'd8; base = dv_cnt;
    send_bit(1'b0, 8);
    send_bit(1'b0, 8);
    send_bit(1'b1, 8);
    send_bit(1'b0, 8);
    rst_n = 1'b0;
    @(negedge CLK);
    chk("mr_p_data", 32'(P_DATA), 32'h00);
    chk("mr_dv",     32'(Data_Valid), 32'h0);
    chk("mr_perr",   32'(Parity_Error), 32'h0);
    chk("mr_ferr",   32'(Frame_Error), 32'h0);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    rst_n = 1'b1;
    repeat (10) @(negedge CLK);
    chk("mr_dv_count", 32'(dv_cnt - base), 32'd0);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 6'd0);
    send_bit(1'b1, 4);
    chk("11_dv_count", 32'(dv_cnt - base), 32'd1);
    chk("11_dv_data",  32'(dv_data_q[$]), 32'h11);
    chk("11_latency",  32'(dv_cyc_q[$] - start_cyc), 32'd80);

    chk("dv_pulse_width", 32'(dv_wide), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
